sccb_init_sequencer: RTL

Sequences camera register configuration at power-up or on request. Walks a fixed register table of {reg, value} pairs and issues one write per entry to the I2C/SCCB master. Handles post-reset delays, inter-write gaps, NACK/timeout retries and completion reporting. Sits between the PLL-locked reset domain (clk) and the I2C controller; gates `busy`/LED status for the capture path.

---
 rtl/sccb_init_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sccb_init_sequencer.sv
// Power-up register loader for an SCCB/I2C camera: walks a fixed {reg, value}
// table, issuing one write per entry with delays, inter-write gaps and retries.
module sccb_init_sequencer #(
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         GAP_CYCLES = 256,
  parameter int         DELAY_UNIT = 50000,
  parameter int         BOOT_WAIT  = 1000,
  parameter int         TIMEOUT    = 65535,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       start,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       wreq,
  output logic [7:0] dev_addr,
  output logic [7:0] waddr,
  output logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] index
);

  localparam logic [3:0] S_BOOT  = 4'd0;
  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_FETCH = 4'd2;
  localparam logic [3:0] S_ISSUE = 4'd3;
  localparam logic [3:0] S_WAIT  = 4'd4;
  localparam logic [3:0] S_GAP   = 4'd5;
  localparam logic [3:0] S_DELAY = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERROR = 4'd8;

  localparam logic [31:0] BOOT_LEN  = 32'(BOOT_WAIT);
  localparam logic [31:0] GAP_LEN   = 32'(GAP_CYCLES);
  localparam logic [31:0] TMO_LEN   = 32'(TIMEOUT);
  localparam logic [39:0] UNIT_LEN  = 40'(DELAY_UNIT);
  localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

  // Register FF marks a delay of value*DELAY_UNIT cycles, FE ends the table.
  function automatic logic [15:0] table_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    table_entry = 16'h1280;
      5'd1:    table_entry = 16'hFF01;
      5'd2:    table_entry = 16'h1214;
      5'd3:    table_entry = 16'h40D0;
      5'd4:    table_entry = 16'h8C00;
      5'd5:    table_entry = 16'h1101;
      5'd6:    table_entry = 16'h3A04;
      default: table_entry = 16'hFE00;
    endcase
  endfunction

  logic [3:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [4:0]  index_q, index_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wreq_q, wreq_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] entry;
  logic [39:0] delay_len;

  assign entry     = table_entry(index_q);
  assign delay_len = {32'd0, wdata_q} * UNIT_LEN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    retry_d = retry_q;
    index_d = index_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wreq_d  = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (cnt_q + 32'd1 >= BOOT_LEN) begin
          state_d = AUTO_START ? S_FETCH : S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE, S_DONE, S_ERROR: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_FETCH;
          index_d = '0;
          retry_d = '0;
        end
      end
      S_FETCH: begin
        cnt_d   = '0;
        waddr_d = entry[15:8];
        wdata_d = entry[7:0];
        if (index_q == 5'd31 || entry[15:8] == 8'hFE) state_d = S_DONE;
        else if (entry[15:8] == 8'hFF)                 state_d = S_DELAY;
        else                                           state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (!i2c_busy) begin
          wreq_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A NACK and a timeout are the same failed attempt.
        if (i2c_done && !i2c_nack) begin
          state_d = S_GAP;
          cnt_d   = '0;
          index_d = index_q + 5'd1;
          retry_d = '0;
        end else if ((i2c_done && i2c_nack) || (cnt_q + 32'd1 >= TMO_LEN)) begin
          cnt_d   = '0;
          retry_d = retry_q + 8'd1;
          state_d = (retry_q + 8'd1 == RETRY_LIM) ? S_ERROR : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q + 32'd1 >= GAP_LEN) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_DELAY: begin
        if ({8'd0, cnt_q} + 40'd1 >= delay_len) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          index_d = index_q + 5'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase
    busy_d  = !(state_d == S_BOOT || state_d == S_IDLE ||
                state_d == S_DONE || state_d == S_ERROR);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
      retry_q <= '0;
      index_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wreq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      index_q <= index_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wreq_q  <= wreq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign wreq     = wreq_q;
  assign dev_addr = DEV_ADDR;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign index    = index_q;

endmodule
